// File: rtl/spi_master_ctrl_pkg.sv
// rtl/spi_master_ctrl_pkg.sv - shared state and mode encodings for the SPI master controller
package spi_master_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_TRANSFER = 2'd2,
        ST_HOLD     = 2'd3
    } spi_master_state_e;

    // Mode numbers as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // True when the mode samples MISO on the leading sclk edge
    function automatic logic samples_on_lead(input logic [1:0] mode);
        return (mode == SPI_MODE0) || (mode == SPI_MODE2);
    endfunction

    // True when the mode shifts MOSI on the leading sclk edge
    function automatic logic shifts_on_lead(input logic [1:0] mode);
        return (mode == SPI_MODE1) || (mode == SPI_MODE3);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period counter producing sclk level and edge strobes
module spi_sclk_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 tgl_en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 idle_level_i,
    output logic                 hp_end_o,
    output logic                 lead_edge_o,
    output logic                 trail_edge_o,
    output logic                 sclk_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 hp_end;

    // Strobes are asserted in the cycle whose closing clock edge moves sclk
    assign hp_end       = !load_i && (cnt_q == div_i);
    assign hp_end_o     = hp_end;
    assign lead_edge_o  = hp_end && tgl_en_i && (sclk_q == idle_level_i);
    assign trail_edge_o = hp_end && tgl_en_i && (sclk_q != idle_level_i);
    assign sclk_o       = sclk_q;

    // Next-state: load parks the counter and sclk at the idle level
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (load_i) begin
            cnt_d  = '0;
            sclk_d = idle_level_i;
        end else if (hp_end) begin
            cnt_d = '0;
            if (tgl_en_i) begin
                sclk_d = ~sclk_q;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and sclk registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master FSM, shift registers and pins; SPI_LSB_FIRST_EN adds lsb_first
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  baud_div,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi0,
    input  logic                  miso0
);

    localparam int HP_W = $clog2(2 * DATA_WIDTH);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_WIDTH - 1);

    spi_master_state_e     state_q;
    logic                  cpol_q, cpha_q, lsb_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [HP_W-1:0]       hp_cnt_q;
    logic                  mosi_q, mosi_d;
    logic                  cs_q, busy_q, done_q;

    logic                  lsb_sel;
    logic [DATA_WIDTH-1:0] tx_ordered;
    logic                  gen_load, tgl_en, idle_level;
    logic                  hp_end, lead_edge, trail_edge;
    logic                  edge_first, edge_last;
    logic                  sample_en, shift_en;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_sel = lsb_first;
`else
    assign lsb_sel = 1'b0;
`endif

    // Present the word so that the first bit on the wire is always the MSB
    always_comb begin
        tx_ordered = tx_data;
        if (lsb_sel) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                tx_ordered[i] = tx_data[DATA_WIDTH-1-i];
            end
        end
    end

    // Edge 0 closes SETUP; edges 1..2N-1 close all but the last TRANSFER half-period
    always_comb begin
        gen_load   = (state_q == ST_IDLE);
        idle_level = (state_q == ST_IDLE) ? cpol : cpol_q;
        tgl_en     = (state_q == ST_SETUP) ||
                     ((state_q == ST_TRANSFER) && (hp_cnt_q != HP_LAST));
        edge_first = (state_q == ST_SETUP);
        edge_last  = (state_q == ST_TRANSFER) && (hp_cnt_q == HP_LAST - 1'b1);
        sample_en  = samples_on_lead({cpol_q, cpha_q}) ? lead_edge : trail_edge;
        shift_en   = shifts_on_lead({cpol_q, cpha_q}) ? (lead_edge && !edge_first)
                                                      : (trail_edge && !edge_last);
    end

    // Shift-register next state; MISO uses its value from before the sclk edge
    always_comb begin
        tx_sr_d = tx_sr_q;
        mosi_d  = mosi_q;
        rx_sr_d = rx_sr_q;
        if (shift_en) begin
            tx_sr_d = tx_sr_q << 1;
            mosi_d  = tx_sr_q[DATA_WIDTH-2];
        end
        if (sample_en) begin
            rx_sr_d = lsb_q ? {miso0, rx_sr_q[DATA_WIDTH-1:1]}
                            : {rx_sr_q[DATA_WIDTH-2:0], miso0};
        end
    end

    spi_sclk_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_sclk_gen (
        .clk_i       (pclk),
        .rst_i       (areset),
        .load_i      (gen_load),
        .tgl_en_i    (tgl_en),
        .div_i       (div_q),
        .idle_level_i(idle_level),
        .hp_end_o    (hp_end),
        .lead_edge_o (lead_edge),
        .trail_edge_o(trail_edge),
        .sclk_o      (sclk)
    );

    // Transfer sequencing with registered pin and handshake outputs
    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            div_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            hp_cnt_q  <= '0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            tx_sr_q <= tx_sr_d;
            mosi_q  <= mosi_d;
            rx_sr_q <= rx_sr_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_SETUP;
                        cs_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        lsb_q    <= lsb_sel;
                        div_q    <= baud_div;
                        tx_sr_q  <= tx_ordered;
                        mosi_q   <= tx_ordered[DATA_WIDTH-1];
                        rx_sr_q  <= '0;
                        hp_cnt_q <= '0;
                    end
                end
                ST_SETUP: begin
                    if (hp_end) begin
                        state_q <= ST_TRANSFER;
                    end
                end
                ST_TRANSFER: begin
                    if (hp_end) begin
                        hp_cnt_q <= hp_cnt_q + 1'b1;
                        if (hp_cnt_q == HP_LAST) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hp_end) begin
                        state_q   <= ST_IDLE;
                        cs_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sr_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign cs      = cs_q;
    assign mosi0   = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench with a behavioural SPI slave for spi_master_ctrl
module tb_spi_master_ctrl;

    localparam int DW  = 8;
    localparam int DVW = 8;
    localparam int PER = 10;

    logic           pclk = 1'b0;
    logic           areset;
    logic           start;
    logic [DW-1:0]  tx_data;
    logic           cpol, cpha;
    logic [DVW-1:0] baud_div;
    logic           lsb_first;
    logic           busy, done, sclk, cs, mosi0;
    logic [DW-1:0]  rx_data;
    logic           miso0;

    always #(PER/2) pclk = ~pclk;

    spi_master_ctrl #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
        .pclk     (pclk),
        .areset   (areset),
        .start    (start),
        .tx_data  (tx_data),
        .cpol     (cpol),
        .cpha     (cpha),
        .baud_div (baud_div),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sclk     (sclk),
        .cs       (cs),
        .mosi0    (mosi0),
        .miso0    (miso0)
    );

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
        logic          pol;
        time           t0;
        int            lat;
    } exp_t;

    typedef struct {
        logic [DW-1:0] srx;
        logic          pol;
        logic          ph;
        logic          lsb;
    } slv_t;

    exp_t          exp_q[$];
    slv_t          slv_q[$];
    logic [DW-1:0] cap_q[$];
    int            checks    = 0;
    int            failures  = 0;
    int            done_cnt  = 0;
    int            exp_dones = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected response: slave word back, TX word captured by slave, fixed latency
    task automatic push_exp(input logic [DW-1:0] tx, input logic [DW-1:0] srx,
                            input logic pol, input logic ph, input int bd, input logic lsb);
        exp_t e;
        slv_t s;
        e.tx  = tx;
        e.rx  = srx;
        e.pol = pol;
        e.t0  = $time;
        e.lat = 1 + (2 * DW + 2) * (bd + 1);
        exp_q.push_back(e);
        s.srx = srx;
        s.pol = pol;
        s.ph  = ph;
        s.lsb = lsb;
        slv_q.push_back(s);
        exp_dones++;
    endtask

    // Behavioural SPI slave reacting to the observed pins
    slv_t          sd;
    logic          s_active = 1'b0;
    logic          prev_cs = 1'b1, prev_sclk = 1'b0;
    int            n_tx, n_rx;
    logic [DW-1:0] s_cap;

    function automatic logic sbit(input slv_t d, input int k);
        return d.lsb ? d.srx[k] : d.srx[DW-1-k];
    endfunction

    task automatic s_capture();
        if (n_rx < DW) begin
            if (sd.lsb) s_cap[n_rx] = mosi0;
            else        s_cap[DW-1-n_rx] = mosi0;
            n_rx++;
            if (n_rx == DW) cap_q.push_back(s_cap);
        end
    endtask

    always @(negedge pclk) begin
        if (prev_cs && !cs) begin
            if (slv_q.size() == 0) begin
                chk("slave_desc_avail", 32'd0, 32'd1);
                sd = '{srx: '0, pol: 1'b0, ph: 1'b0, lsb: 1'b0};
            end else begin
                sd = slv_q.pop_front();
            end
            s_active = 1'b1;
            n_tx = 0;
            n_rx = 0;
            s_cap = '0;
            if (!sd.ph) begin
                miso0 = sbit(sd, 0);
                n_tx = 1;
            end
        end else if (!cs && s_active && (sclk != prev_sclk)) begin
            if (sclk != sd.pol) begin
                if (!sd.ph) s_capture();
                else if (n_tx < DW) begin
                    miso0 = sbit(sd, n_tx);
                    n_tx++;
                end
            end else begin
                if (sd.ph) s_capture();
                else if (n_tx < DW) begin
                    miso0 = sbit(sd, n_tx);
                    n_tx++;
                end
            end
        end
        if (cs) s_active = 1'b0;
        prev_cs   = cs;
        prev_sclk = sclk;
    end

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge pclk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e.rx));
                chk("done_latency", 32'(($time - e.t0) / PER), 32'(e.lat));
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("cs_in_done", 32'(cs), 32'd1);
                chk("sclk_idle_level", 32'(sclk), 32'(e.pol));
                if (cap_q.size() == 0) chk("mosi_word_captured", 32'd0, 32'd1);
                else chk("mosi_word", 32'(cap_q.pop_front()), 32'(e.tx));
            end
        end
    end

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (done) return;
            @(negedge pclk);
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [DW-1:0] tx, input logic [DW-1:0] srx,
                         input logic pol, input logic ph, input int bd, input logic lsb);
        tx_data   = tx;
        cpol      = pol;
        cpha      = ph;
        baud_div  = DVW'(bd);
        lsb_first = lsb;
        start     = 1'b1;
        push_exp(tx, srx, pol, ph, bd, lsb);
        @(negedge pclk);
        start = 1'b0;
        chk("cs_low_after_start", 32'(cs), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; tx_data = '0; cpol = 1'b0; cpha = 1'b0;
        baud_div = '0; lsb_first = 1'b0; miso0 = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", 32'(rx_data), 32'd0);
        areset = 1'b0;
        @(negedge pclk);

        // All four modes with the reference word pair
        for (int m = 0; m < 4; m++) begin
            issue(8'hA5, 8'h3C, m[1], m[0], 1, 1'b0);
            wait_done(200);
            @(negedge pclk);
            chk("idle_sclk_follows_cpol", 32'(sclk), 32'(m[1]));
        end
        cpol = 1'b1;
        @(negedge pclk);
        chk("idle_sclk_live_cpol", 32'(sclk), 32'd1);
        cpol = 1'b0;
        @(negedge pclk);

        // Fastest divider
        issue(8'h5A, 8'hC3, 1'b0, 1'b1, 0, 1'b0);
        wait_done(100);
        @(negedge pclk);

        // Start pulse during TRANSFER must be ignored
        issue(8'h96, 8'h69, 1'b1, 1'b0, 1, 1'b0);
        repeat (8) @(negedge pclk);
        tx_data = 8'hFF; cpol = 1'b0; start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        wait_done(200);
        repeat (5) @(negedge pclk);

        // Back-to-back with start held high
        tx_data = 8'h81; cpol = 1'b0; cpha = 1'b0; baud_div = 8'd1; start = 1'b1;
        push_exp(8'h81, 8'h7E, 1'b0, 1'b0, 1, 1'b0);
        @(negedge pclk);
        chk("b2b_first_cs_low", 32'(cs), 32'd0);
        wait_done(200);
        chk("b2b_cs_high_in_done", 32'(cs), 32'd1);
        tx_data = 8'h42; cpol = 1'b1; cpha = 1'b1;
        push_exp(8'h42, 8'hBD, 1'b1, 1'b1, 1, 1'b0);
        @(negedge pclk);
        start = 1'b0;
        chk("b2b_cs_high_one_cycle", 32'(cs), 32'd0);
        wait_done(200);
        @(negedge pclk);

        // Reset ten cycles into a transfer
        issue(8'hF0, 8'h0F, 1'b0, 1'b0, 1, 1'b0);
        repeat (9) @(negedge pclk);
        areset = 1'b1;
        exp_dones -= exp_q.size();
        exp_q.delete();
        slv_q.delete();
        cap_q.delete();
        @(negedge pclk);
        areset = 1'b0;
        chk("rst_mid_cs", 32'(cs), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rx", 32'(rx_data), 32'd0);
        repeat (50) @(negedge pclk);
        issue(8'hA5, 8'h3C, 1'b0, 1'b0, 1, 1'b0);
        wait_done(200);
        @(negedge pclk);

`ifdef SPI_LSB_FIRST_EN
        issue(8'h01, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
        chk("lsb_first_bit", 32'(mosi0), 32'd1);
        wait_done(200);
        @(negedge pclk);
`endif

        // Randomised transfers
        for (int n = 0; n < 20; n++) begin
            logic lsb;
            lsb = 1'b0;
`ifdef SPI_LSB_FIRST_EN
            lsb = 1'($urandom_range(0, 1));
`endif
            issue(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), lsb);
            wait_done(200);
            repeat ($urandom_range(1, 3)) @(negedge pclk);
        end

        repeat (10) @(negedge pclk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(exp_dones));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
